// File: rtl/or1k_branch_target_buffer.sv
// Direct-mapped branch target buffer: 1-cycle lookup, trained at branch resolution.
// Optional lookup/hit statistics counters enabled by OR1K_BTB_STATS_EN.
module or1k_branch_target_buffer #(
    parameter int OPTION_OPERAND_WIDTH = 32,
    parameter int BTB_INDEX_WIDTH      = 6,
    parameter int BTB_TAG_WIDTH        = 10
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            padv_fetch_i,
    input  logic                            lookup_valid_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] lookup_pc_i,
    output logic                            hit_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] target_o,
    input  logic                            update_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] update_pc_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] update_target_i,
    input  logic                            update_taken_i,
    input  logic                            flush_i,
    output logic                            busy_o,
    output logic [31:0]                     lookup_count_o,
    output logic [31:0]                     hit_count_o
);
    localparam int ENTRIES = 1 << BTB_INDEX_WIDTH;
    localparam int TAG_LO  = BTB_INDEX_WIDTH + 2;
    localparam int TAG_HI  = BTB_INDEX_WIDTH + BTB_TAG_WIDTH + 1;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t                            state_q, state_d;
    logic [BTB_INDEX_WIDTH-1:0]        cnt_q, cnt_d;
    logic                              hit_q, hit_d;
    logic [OPTION_OPERAND_WIDTH-1:0]   target_q, target_d;

    logic                              valid_mem  [ENTRIES];
    logic [BTB_TAG_WIDTH-1:0]          tag_mem    [ENTRIES];
    logic [OPTION_OPERAND_WIDTH-1:0]   target_mem [ENTRIES];

    logic [BTB_INDEX_WIDTH-1:0]        lk_idx, up_idx, wr_idx;
    logic [BTB_TAG_WIDTH-1:0]          lk_tag, up_tag, wr_tag;
    logic                              wr_en, wr_valid, run, lk_hit, up_match, sweep_we;
    logic [OPTION_OPERAND_WIDTH-1:0]   wr_target;
    logic                              unused_pc_bits;

    assign lk_idx = lookup_pc_i[BTB_INDEX_WIDTH+1:2];
    assign lk_tag = lookup_pc_i[TAG_HI:TAG_LO];
    assign up_idx = update_pc_i[BTB_INDEX_WIDTH+1:2];
    assign up_tag = update_pc_i[TAG_HI:TAG_LO];
    assign unused_pc_bits = ^{lookup_pc_i, update_pc_i};

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (flush_i) begin
            state_d = ST_INIT;
            cnt_d   = '0;
        end else if (state_q == ST_INIT) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == '1) state_d = ST_RUN;
        end
    end

    // FSM outputs
    always_comb begin
        run      = (state_q == ST_RUN);
        busy_o   = (state_q == ST_INIT);
        sweep_we = (state_q == ST_INIT);
    end

    // Single write port: the sweep owns it in INIT; flush-cycle updates are dropped.
    always_comb begin
        lk_hit    = lookup_valid_i & run & valid_mem[lk_idx] & (tag_mem[lk_idx] == lk_tag);
        up_match  = valid_mem[up_idx] & (tag_mem[up_idx] == up_tag);
        wr_en     = 1'b0;
        wr_idx    = up_idx;
        wr_valid  = 1'b0;
        wr_tag    = up_tag;
        wr_target = update_target_i;
        if (sweep_we) begin
            wr_en     = 1'b1;
            wr_idx    = cnt_q;
            wr_tag    = '0;
            wr_target = '0;
        end else if (update_i && !flush_i) begin
            wr_en    = update_taken_i | up_match;
            wr_valid = update_taken_i;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            valid_mem[wr_idx]  <= wr_valid;
            tag_mem[wr_idx]    <= wr_tag;
            target_mem[wr_idx] <= wr_target;
        end
    end

    always_comb begin
        hit_d    = hit_q;
        target_d = target_q;
        if (padv_fetch_i) begin
            hit_d = lk_hit;
            if (lk_hit) target_d = target_mem[lk_idx];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_q    <= 1'b0;
            target_q <= '0;
        end else begin
            hit_q    <= hit_d;
            target_q <= target_d;
        end
    end

    assign hit_o    = hit_q;
    assign target_o = target_q;

`ifdef OR1K_BTB_STATS_EN
    logic [31:0] lookup_cnt_q, lookup_cnt_d, hit_cnt_q, hit_cnt_d;

    always_comb begin
        lookup_cnt_d = lookup_cnt_q;
        hit_cnt_d    = hit_cnt_q;
        if (padv_fetch_i && lookup_valid_i && run) begin
            if (lookup_cnt_q != '1) lookup_cnt_d = lookup_cnt_q + 32'd1;
            if (lk_hit && hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lookup_cnt_q <= '0;
            hit_cnt_q    <= '0;
        end else begin
            lookup_cnt_q <= lookup_cnt_d;
            hit_cnt_q    <= hit_cnt_d;
        end
    end

    assign lookup_count_o = lookup_cnt_q;
    assign hit_count_o    = hit_cnt_q;
`else
    assign lookup_count_o = '0;
    assign hit_count_o    = '0;
`endif
endmodule

// File: doc/or1k_branch_target_buffer.md
Name: or1k_branch_target_buffer

Overview:
Direct-mapped branch target buffer (BTB) in the fetch stage, directly upstream of the decode-stage branch predictor. It supplies a predicted target PC for fetch redirection, one cycle after a PC lookup. It is trained from the resolution stage with the branch PC, the resolved target and the taken outcome. Tag, target and valid storage is RAM-style (no reset), so the valid bits are cleared by a sequential init/flush sweep.

Parameters:
OPTION_OPERAND_WIDTH, 32, PC and target width.
BTB_INDEX_WIDTH, 6, log2 of the entry count (default 64 entries).
BTB_TAG_WIDTH, 10, stored tag bits.

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
padv_fetch_i  in  1  fetch advance; lookup result registers only when high
lookup_valid_i  in  1  lookup request this cycle
lookup_pc_i  in  OPTION_OPERAND_WIDTH  PC being fetched
hit_o  out  1  registered: previous accepted lookup hit
target_o  out  OPTION_OPERAND_WIDTH  registered predicted target
update_i  in  1  resolved branch training strobe
update_pc_i  in  OPTION_OPERAND_WIDTH  resolved branch PC
update_target_i  in  OPTION_OPERAND_WIDTH  resolved target
update_taken_i  in  1  resolved outcome
flush_i  in  1  invalidate all entries (e.g. on context switch / cache invalidate)
busy_o  out  1  sweep in progress
lookup_count_o  out  32  stats, see Optional Feature
hit_count_o  out  32  stats, see Optional Feature

Behaviour:
- Index = pc[BTB_INDEX_WIDTH+1:2]. Tag = pc[BTB_INDEX_WIDTH+BTB_TAG_WIDTH+1:BTB_INDEX_WIDTH+2].
- Entry contents: valid, tag, target.
- Reset values: hit_o=0, target_o=0, busy_o=1, state=INIT, sweep counter=0, both stats counters=0.
- FSM states: INIT and RUN.
  - INIT: each cycle writes valid=0 at index=counter, then counter+1. When counter reaches 2^BTB_INDEX_WIDTH-1 and that entry is written, go to RUN next cycle. A full sweep takes 2^BTB_INDEX_WIDTH cycles.
  - RUN: busy_o=0.
  - flush_i in RUN: enter INIT with counter=0.
  - flush_i in INIT: restart counter at 0.
  - rst asserted mid-sweep: async return to INIT with counter=0.
- Lookup (1-cycle latency):
  - When padv_fetch_i=1, hit_o <= lookup_valid_i & RUN & entry.valid & (entry.tag == tag(lookup_pc_i)).
  - target_o <= entry.target on a hit; otherwise target_o holds its previous value.
  - When padv_fetch_i=0, hit_o and target_o hold.
  - In INIT, hit_o is forced to 0 when padv_fetch_i=1.
- Update (RUN only; ignored in INIT and in the flush_i cycle):
  - update_taken_i=1: write valid=1, tag, target at index (allocate or overwrite).
  - update_taken_i=0: if the stored entry is valid with matching tag, write valid=0. Otherwise no change.
- Same cycle, same index, lookup and update: the lookup sees pre-update contents (read-before-write). The next lookup sees the new contents.
- One write per cycle. Sweep writes have priority over updates, which are dropped in INIT.
- Storage has no reset.

Optional Feature:
OR1K_BTB_STATS_EN.
- Defined:
  - lookup_count_o increments on each accepted lookup (padv_fetch_i & lookup_valid_i & RUN).
  - hit_count_o increments when such a lookup hits.
  - Both saturate at 0xFFFF_FFFF.
  - Both clear on rst only; flush_i does not clear them.
- Undefined: both ports are tied to 0 and no counter flops exist.

Test Plan:
- Reset: deassert rst, hold padv_fetch_i=1 with lookups -> busy_o=1 for exactly 64 cycles, hit_o=0 throughout, busy_o=0 on cycle 64.
- Allocate: update pc 0x0000_1040, target 0x0000_2000, taken=1. Then look up 0x0000_1040 -> next cycle hit_o=1, target_o=0x0000_2000.
- Alias: after the allocate, look up 0x0002_1040 (same index 0x10, tag 0x210 vs 0x010) -> hit_o=0, target_o unchanged.
- Not-taken invalidate:
  - update 0x0000_1040 taken=0 -> subsequent lookup of 0x1040 gives hit_o=0.
  - update 0x0002_1040 taken=0 while 0x1040 is valid -> 0x1040 still hits.
- Collision and stall:
  - same-cycle lookup and taken update of 0x1040 with target 0x3000, over an existing target of 0x2000 -> target_o=0x2000; next lookup gives 0x3000.
  - padv_fetch_i=0 -> hit_o and target_o hold for all stalled cycles.
- Flush mid-sweep:
  - flush_i in RUN -> busy_o=1 for 64 cycles; updates issued during the sweep are dropped (lookup after the sweep misses).
  - flush_i at sweep counter 30 -> sweep restarts, busy_o=1 for 64 more cycles.
  - With OR1K_BTB_STATS_EN: 10 lookups with 4 hits -> lookup_count_o=10, hit_count_o=4, values retained across the flush.
